// File: rtl/button_conditioner_pkg.sv
// btn_cond_pkg: board clock constants and debounce helpers for the Basys 3 button front end
package btn_cond_pkg;
  localparam int CLK_HZ = 100_000_000;
  function automatic int ms_to_cycles(input int ms);
    return ms * (CLK_HZ / 1000);
  endfunction
  localparam int DEFAULT_DEBOUNCE_CYCLES = ms_to_cycles(10);
  typedef logic [4:0] btn_vec_t;
endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// debounce_channel: one button's synchroniser, integrating debouncer and strobes
// BTN_AUTOREPEAT_EN adds a hold-to-repeat counter that re-fires press.
module debounce_channel #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 24,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int RPT_W = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic press,
  output logic release_pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic sync_out, differ, accept;
  assign sync_out = sync[SYNC_STAGES-1];
  assign differ = sync_out != level;
  assign accept = differ && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_debounce
    $error("debounce_channel: bad SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W");
  end
  if (RPT_W < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      longint'(REPEAT_DELAY) > (longint'(1) << RPT_W) || longint'(REPEAT_PERIOD) > (longint'(1) << RPT_W)) begin : g_bad_repeat
    $error("debounce_channel: bad REPEAT_DELAY/REPEAT_PERIOD/RPT_W");
  end
`ifdef BTN_AUTOREPEAT_EN
  logic [RPT_W-1:0] rpt;
  logic rep, rpt_hit;
  assign rpt_hit = rpt == (rep ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1));
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt <= '0;
      rep <= 1'b0;
`endif
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], button};
      cnt <= differ && !accept ? cnt + 1'b1 : '0;
      if (accept) level <= sync_out;
      release_pulse <= accept && !sync_out;
`ifdef BTN_AUTOREPEAT_EN
      // an accepted release wins over a coincident repeat hit
      press <= accept ? sync_out : level && rpt_hit;
      rpt <= !level || accept || rpt_hit ? '0 : rpt + 1'b1;
      rep <= level && !accept && (rep || rpt_hit);
`else
      press <= accept && sync_out;
`endif
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N independent debounced button channels with press/release strobes
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat press strobes.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 24,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int RPT_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] button_in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_press
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W(CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .RPT_W(RPT_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .button(button_in[i]),
      .level(level[i]),
      .press(press[i]),
      .release_pulse(release_pulse[i])
    );
  end
  assign any_press = |press;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce timing, glitch rejection, reset and auto-repeat
module tb_button_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] button_in = '0;
  logic [4:0] level, press, release_pulse;
  logic any_press;
  int checks = 0;
  int errors = 0;
  int widths [2] = '{5, 7};
  always #5 clk = ~clk;
  button_conditioner #(
    .N_BTN(5), .SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(6), .RPT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in), .level(level),
    .press(press), .release_pulse(release_pulse), .any_press(any_press)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) step();
    check("rst_all", {level, press, release_pulse, any_press}, 0);
    for (int k = 0; k < 10; k++) begin
      button_in = 5'(k * 7);
      step();
      check("rst_hold", {level, press, release_pulse, any_press}, 0);
    end
    button_in = '0;
    repeat (3) step();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("rst_exit", {level, press, release_pulse, any_press}, 0);
    end
    button_in[0] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      check("t2_level", 32'(level[0]), 32'(k >= 10));
      check("t2_press", 32'(press[0]), 32'(k == 10));
      check("t2_any", 32'(any_press), 32'(k == 10));
    end
    foreach (widths[w]) begin
      button_in[2] = 1'b1;
      for (int k = 1; k <= widths[w]; k++) begin
        step();
        check("t3_glitch_hi", {29'd0, level[2], press[2], release_pulse[2]}, 0);
      end
      button_in[2] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
        step();
        check("t3_glitch_lo", {29'd0, level[2], press[2], release_pulse[2]}, 0);
      end
    end
    button_in[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      check("t4_level", 32'(level[0]), 32'(k < 10));
      check("t4_release", 32'(release_pulse[0]), 32'(k == 10));
    end
    button_in[1] = 1'b1;
    button_in[3] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t5_press1", 32'(press[1]), 32'(k == 10));
      check("t5_press3", 32'(press[3]), 32'(k == 10));
      check("t5_any", 32'(any_press), 32'(k == 10));
    end
    button_in[4] = 1'b1;
    repeat (6) step();
    reset = 1'b1;
    #1;
    check("t5_rst_async", {level, press, release_pulse, any_press}, 0);
    step();
    check("t5_rst_held", {level, press, release_pulse, any_press}, 0);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t5_lvl4", 32'(level[4]), 32'(k >= 10));
      check("t5_press4", 32'(press[4]), 32'(k == 10));
      check("t5_rel", 32'(release_pulse), 0);
    end
`ifdef BTN_AUTOREPEAT_EN
    button_in = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    button_in[4] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      check("t6_rpt", 32'(press[4]), 32'(k == 10 || (k >= 30 && (k - 30) % 6 == 0)));
    end
    button_in[4] = 1'b0;
    for (int k = 51; k <= 70; k++) begin
      step();
      check("t6_rpt_rel", 32'(press[4]), 32'(k < 60 && (k - 30) % 6 == 0));
      check("t6_release", 32'(release_pulse[4]), 32'(k == 60));
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
